// File: rtl/duc_dac.sv
// Self-stimulated digital up-converter: PRBS QPSK baseband, zero-order hold, NCO mix, 3-stage pipeline.
// Define DUC_ROUND_EN to round half up before the Q15 rescale (default build truncates toward -inf).
module duc_dac #(
  parameter int PHASE_INC = 16,
  parameter int INTERP    = 16,
  parameter int BB_AMP    = 16384,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic                     ValidIn,
  output logic                     ce_out,
  output logic signed [DATA_W-1:0] Out1_re_out,
  output logic signed [DATA_W-1:0] Out1_im_out,
  output logic                     Out2
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int CNT_W  = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERP - 1);
  localparam logic [7:0] PINC = 8'(PHASE_INC);
  localparam logic signed [DATA_W-1:0] AMP_P = DATA_W'(BB_AMP);
  localparam logic signed [DATA_W-1:0] AMP_N = DATA_W'(-BB_AMP);
  localparam logic signed [SUM_W-1:0]  SAT_MAX = SUM_W'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0]  SAT_MIN = -SAT_MAX - 1;
`ifdef DUC_ROUND_EN
  localparam logic signed [SUM_W-1:0]  HALF_LSB = SUM_W'(16384);
`endif

  // First quadrant of round(32767*sin(2*pi*k/256)), k = 0..64
  localparam logic signed [COEF_W-1:0] QTR [65] = '{
    16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
    16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
    16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
    16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
    16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
    16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
    16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
    16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757,
    16'd32767
  };

  function automatic logic signed [COEF_W-1:0] sin_lut(input logic [7:0] k);
    logic [6:0]               idx;
    logic signed [COEF_W-1:0] mag;
    idx = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
    mag = QTR[idx];
    return k[7] ? -mag : mag;
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] l);
    return {l[5:0], l[6] ^ l[5]};
  endfunction

  function automatic logic signed [SUM_W-1:0] scale_q15(input logic signed [SUM_W-1:0] s);
`ifdef DUC_ROUND_EN
    return (s + HALF_LSB) >>> 15;
`else
    return s >>> 15;
`endif
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_q15(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction

  logic                     accept;
  logic [7:0]               phase;
  logic [6:0]               lfsr;
  logic [CNT_W-1:0]         hold_cnt;

  logic                     vld_p0, vld_p1, vld_p2;
  logic signed [COEF_W-1:0] cos_p0, sin_p0;
  logic signed [DATA_W-1:0] i_p0, q_p0;
  logic signed [PROD_W-1:0] ic_p1, qs_p1, is_p1, qc_p1;
  logic signed [SUM_W-1:0]  sum_re, sum_im;
  logic signed [DATA_W-1:0] re_p2, im_p2;

  assign accept = clk_enable & ValidIn;
  assign ce_out = clk_enable;

  // Only accepted samples advance the NCO and the symbol source, so gaps never skip a sample.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      lfsr     <= 7'h7F;
      hold_cnt <= '0;
    end else if (accept) begin
      phase <= phase + PINC;
      if (hold_cnt == CNT_LAST) begin
        hold_cnt <= '0;
        lfsr     <= lfsr_step(lfsr_step(lfsr));
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // S1: carrier lookup and symbol mapping
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      cos_p0 <= '0;
      sin_p0 <= '0;
      i_p0   <= '0;
      q_p0   <= '0;
    end else if (clk_enable) begin
      vld_p0 <= ValidIn;
      cos_p0 <= sin_lut(phase + 8'd64);
      sin_p0 <= sin_lut(phase);
      i_p0   <= lfsr[6] ? AMP_N : AMP_P;
      q_p0   <= lfsr[5] ? AMP_N : AMP_P;
    end
  end

  // S2: full-precision products
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      ic_p1  <= '0;
      qs_p1  <= '0;
      is_p1  <= '0;
      qc_p1  <= '0;
    end else if (clk_enable) begin
      vld_p1 <= vld_p0;
      ic_p1  <= i_p0 * cos_p0;
      qs_p1  <= q_p0 * sin_p0;
      is_p1  <= i_p0 * sin_p0;
      qc_p1  <= q_p0 * cos_p0;
    end
  end

  always_comb begin
    sum_re = {ic_p1[PROD_W-1], ic_p1} - {qs_p1[PROD_W-1], qs_p1};
    sum_im = {is_p1[PROD_W-1], is_p1} + {qc_p1[PROD_W-1], qc_p1};
  end

  // S3: rescale to Q1.15, saturate, zero the data when not valid
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      re_p2  <= '0;
      im_p2  <= '0;
    end else if (clk_enable) begin
      vld_p2 <= vld_p1;
      re_p2  <= vld_p1 ? sat_q15(scale_q15(sum_re)) : '0;
      im_p2  <= vld_p1 ? sat_q15(scale_q15(sum_im)) : '0;
    end
  end

  assign Out1_re_out = re_p2;
  assign Out1_im_out = im_p2;
  assign Out2        = vld_p2;

endmodule

// File: tb/tb_duc_dac.sv
// Directed-vector bench for duc_dac: hand-computed table for the first samples plus a
// reference model for gaps, enable freeze, phase/symbol wrap and mid-stream reset.
module tb_duc_dac;

  logic               clk_in = 1'b0;
  logic               rst;
  logic               clk_enable;
  logic               ValidIn;
  logic               ce_out;
  logic signed [15:0] Out1_re_out;
  logic signed [15:0] Out1_im_out;
  logic               Out2;

  always #5 clk_in = ~clk_in;

  duc_dac dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .clk_enable  (clk_enable),
    .ValidIn     (ValidIn),
    .ce_out      (ce_out),
    .Out1_re_out (Out1_re_out),
    .Out1_im_out (Out1_im_out),
    .Out2        (Out2)
  );

`ifdef DUC_ROUND_EN
  localparam int S0    = -16383;
  localparam int S4_RE = 16384;
`else
  localparam int S0    = -16384;
  localparam int S4_RE = 16383;
`endif
  localparam real PI = 3.14159265358979323846;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model state
  logic [7:0] m_phase;
  logic [6:0] m_lfsr;
  int         m_cnt;
  int         m_n;
  bit         m_vld [3];
  int         m_re  [3];
  int         m_im  [3];
  int         m_idx [3];

  function automatic longint ref_sin(input int k);
    real v;
    v = 32767.0 * $sin(2.0 * PI * real'(k) / 256.0);
    if (v >= 0.0) return longint'($rtoi($floor(v + 0.5)));
    else          return -longint'($rtoi($floor(-v + 0.5)));
  endfunction

  function automatic int clamp16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic logic [6:0] lfsr_nxt(input logic [6:0] l);
    return {l[5:0], l[6] ^ l[5]};
  endfunction

  function automatic void ref_out(input int ph, input logic [6:0] l, output int re, output int im);
    longint c, s, i, q, sr, si;
    s  = ref_sin(ph);
    c  = ref_sin((ph + 64) % 256);
    i  = l[6] ? -16384 : 16384;
    q  = l[5] ? -16384 : 16384;
    sr = i * c - q * s;
    si = i * s + q * c;
`ifdef DUC_ROUND_EN
    sr = sr + 16384;
    si = si + 16384;
`endif
    re = clamp16(sr >>> 15);
    im = clamp16(si >>> 15);
  endfunction

  task automatic model_reset();
    m_phase = 8'd0;
    m_lfsr  = 7'h7F;
    m_cnt   = 0;
    m_n     = 0;
    for (int k = 0; k < 3; k++) begin
      m_vld[k] = 1'b0; m_re[k] = 0; m_im[k] = 0; m_idx[k] = -1;
    end
  endtask

  task automatic model_edge(input bit ce, input bit vin);
    int re, im;
    if (!ce) return;
    for (int k = 2; k > 0; k--) begin
      m_vld[k] = m_vld[k-1]; m_re[k] = m_re[k-1]; m_im[k] = m_im[k-1]; m_idx[k] = m_idx[k-1];
    end
    m_vld[0] = vin; m_re[0] = 0; m_im[0] = 0; m_idx[0] = -1;
    if (vin) begin
      ref_out(int'(m_phase), m_lfsr, re, im);
      m_re[0]  = re;
      m_im[0]  = im;
      m_idx[0] = m_n;
      m_n++;
      m_phase = m_phase + 8'd16;
      if (m_cnt == 15) begin
        m_cnt  = 0;
        m_lfsr = lfsr_nxt(lfsr_nxt(m_lfsr));
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input bit ce, input bit vin);
    clk_enable = ce;
    ValidIn    = vin;
    @(posedge clk_in);
    #1;
    model_edge(ce, vin);
  endtask

  task automatic check_model(input string tag);
    int mag_re, mag_im;
    check({tag, "_ce_out"}, ce_out, clk_enable);
    check({tag, "_out2"}, Out2, m_vld[2]);
    check({tag, "_re"}, Out1_re_out, m_re[2]);
    check({tag, "_im"}, Out1_im_out, m_im[2]);
    if (m_vld[2]) begin
      mag_re = (Out1_re_out < 0) ? -int'(Out1_re_out) : int'(Out1_re_out);
      mag_im = (Out1_im_out < 0) ? -int'(Out1_im_out) : int'(Out1_im_out);
      check({tag, "_bound"}, (mag_re <= 23170) && (mag_im <= 23170), 1);
      if (m_idx[2] == 16) begin
        check("sample16_re", Out1_re_out, S0);
        check("sample16_im", Out1_im_out, S0);
      end
      if (m_idx[2] == 48) begin
        check("sample48_re", Out1_re_out, S0);
        check("sample48_im", Out1_im_out, S4_RE);
      end
      if (m_idx[2] == 64) begin
        check("sample64_re", Out1_re_out, S4_RE);
        check("sample64_im", Out1_im_out, S4_RE);
      end
    end
  endtask

  typedef struct {
    bit ce;
    bit vin;
    bit out2;
    int re;
    int im;
  } vec_t;

  vec_t vt [9];

  initial begin
    vt[0] = '{1'b1, 1'b1, 1'b0, 0, 0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 0, 0};
    vt[2] = '{1'b1, 1'b1, 1'b1, S0, S0};
    vt[3] = '{1'b1, 1'b1, 1'b1, -8867, -21406};
    vt[4] = '{1'b1, 1'b1, 1'b1, 0, -23170};
    vt[5] = '{1'b1, 1'b1, 1'b1, 8867, -21406};
    vt[6] = '{1'b1, 1'b1, 1'b1, S4_RE, S0};
    vt[7] = '{1'b1, 1'b1, 1'b1, 21406, -8867};
    vt[8] = '{1'b0, 1'b1, 1'b1, 21406, -8867};

    rst = 1'b1; clk_enable = 1'b0; ValidIn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_out2", Out2, 0);
    check("rst_re", Out1_re_out, 0);
    check("rst_im", Out1_im_out, 0);
    check("rst_ce_out_lo", ce_out, 0);
    clk_enable = 1'b1;
    #1;
    check("rst_ce_out_hi", ce_out, 1);
    @(posedge clk_in);
    #1;
    check("rst_hold_out2", Out2, 0);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      step(vt[v].ce, vt[v].vin);
      check($sformatf("vec%0d_out2", v), Out2, vt[v].out2);
      check($sformatf("vec%0d_re", v), Out1_re_out, vt[v].re);
      check($sformatf("vec%0d_im", v), Out1_im_out, vt[v].im);
      check($sformatf("vec%0d_ce_out", v), ce_out, vt[v].ce);
    end

    repeat (2) begin
      step(1'b1, 1'b1);
      check_model("pregap");
    end
    for (int g = 0; g < 5; g++) begin
      step(1'b1, 1'b0);
      check_model("gap");
      if (g == 1) check("gap_out2_still_high", Out2, 1);
      if (g == 2) begin
        check("gap_out2_drop", Out2, 0);
        check("gap_re_zero", Out1_re_out, 0);
        check("gap_im_zero", Out1_im_out, 0);
      end
    end
    repeat (10) begin
      step(1'b1, 1'b1);
      check_model("resume");
    end

    for (int f = 0; f < 4; f++) begin
      step(1'b0, 1'b1);
      check_model("freeze");
    end
    repeat (55) begin
      step(1'b1, 1'b1);
      check_model("wrap");
    end

    #2;
    rst = 1'b1;
    #1;
    check("midrst_out2", Out2, 0);
    check("midrst_re", Out1_re_out, 0);
    check("midrst_im", Out1_im_out, 0);
    model_reset();
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    repeat (3) begin
      step(1'b1, 1'b1);
      check_model("restart");
    end
    check("restart_s0_out2", Out2, 1);
    check("restart_s0_re", Out1_re_out, S0);
    check("restart_s0_im", Out1_im_out, S0);
    step(1'b1, 1'b1);
    check("restart_s1_re", Out1_re_out, -8867);
    check("restart_s1_im", Out1_im_out, -21406);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
